// File: rtl/mux_scan_sel.sv
// Registered N-channel, W-bit multiplexer with manual select and auto-scan modes.
// Optional macro MUX_SCAN_SKIP_MASK_EN adds a scan_mask port that skips channels in scan mode.
module mux_scan_sel #(
    parameter int N_CH  = 8,
    parameter int W     = 1,
    parameter int DWELL = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        mode,
    input  logic [$clog2(N_CH)-1:0]     sel_in,
    input  logic [N_CH*W-1:0]           din,
    output logic [W-1:0]                dout,
    output logic [$clog2(N_CH)-1:0]     ch_out,
    output logic                        valid,
    output logic                        wrap
`ifdef MUX_SCAN_SKIP_MASK_EN
    ,
    input  logic [N_CH-1:0]             scan_mask
`endif
);

    localparam int SW = $clog2(N_CH);
    localparam int DW = $clog2(DWELL + 1);

    typedef enum logic [0:0] {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [SW-1:0]   ch_r, ch_s;
    logic [DW-1:0]   dwell_r, dwell_s;
    logic [W-1:0]    dout_s;
    logic [SW-1:0]   ch_out_s;
    logic            valid_s, wrap_s;
    logic [N_CH-1:0] mask_s;
    logic [SW-1:0]   cur_ch_s;
    logic [DW-1:0]   cur_dw_s;
    logic            last_dw_s;

`ifdef MUX_SCAN_SKIP_MASK_EN
    assign mask_s = scan_mask;
`else
    assign mask_s = {N_CH{1'b1}};
`endif

    function automatic logic [SW-1:0] first_ch(input logic [N_CH-1:0] m);
        first_ch = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (m[k]) first_ch = SW'(k);
        end
    endfunction

    function automatic logic [SW-1:0] last_ch(input logic [N_CH-1:0] m);
        last_ch = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (m[k]) last_ch = SW'(k);
        end
    endfunction

    // Next enabled channel strictly above c, wrapping to the lowest enabled one.
    function automatic logic [SW-1:0] next_ch(input logic [N_CH-1:0] m, input logic [SW-1:0] c);
        next_ch = first_ch(m);
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (m[k] && (k > int'(c))) next_ch = SW'(k);
        end
    endfunction

    // FSM follows mode every clock; entry into SCAN is seen as state_r still MANUAL.
    always_comb begin
        state_s = state_r;
        case (state_r)
            MANUAL: if (mode) state_s = SCAN;   else state_s = MANUAL;
            SCAN:   if (mode) state_s = SCAN;   else state_s = MANUAL;
            default: state_s = MANUAL;
        endcase
    end

    // Sample selection and counter update for the next clock.
    always_comb begin
        dout_s    = dout;
        ch_out_s  = ch_out;
        valid_s   = 1'b0;
        wrap_s    = 1'b0;
        ch_s      = ch_r;
        dwell_s   = dwell_r;
        cur_ch_s  = (state_r == SCAN) ? ch_r : first_ch(mask_s);
        cur_dw_s  = (state_r == SCAN) ? dwell_r : DW'(0);
        last_dw_s = (cur_dw_s == DW'(DWELL - 1));
        if (mode) begin
            // Counters are committed even with en=0 so a restart on entry is never lost.
            ch_s    = cur_ch_s;
            dwell_s = cur_dw_s;
            if (en && (|mask_s)) begin
                dout_s   = din[int'(cur_ch_s)*W +: W];
                ch_out_s = cur_ch_s;
                valid_s  = 1'b1;
                wrap_s   = last_dw_s && (cur_ch_s == last_ch(mask_s));
                if (last_dw_s) begin
                    dwell_s = DW'(0);
                    ch_s    = next_ch(mask_s, cur_ch_s);
                end else begin
                    dwell_s = cur_dw_s + DW'(1);
                end
            end else begin
                valid_s = 1'b0;
            end
        end else begin
            ch_s    = '0;
            dwell_s = '0;
            if (en) begin
                ch_out_s = sel_in;
                if (int'(sel_in) < N_CH) begin
                    dout_s  = din[int'(sel_in)*W +: W];
                    valid_s = 1'b1;
                end else begin
                    dout_s  = '0;
                    valid_s = 1'b0;
                end
            end else begin
                valid_s = 1'b0;
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= MANUAL;
            ch_r    <= '0;
            dwell_r <= '0;
            dout    <= '0;
            ch_out  <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_r <= state_s;
            ch_r    <= ch_s;
            dwell_r <= dwell_s;
            dout    <= dout_s;
            ch_out  <= ch_out_s;
            valid   <= valid_s;
            wrap    <= wrap_s;
        end
    end

endmodule
